reg_bus_ctrl: RTL and testbench

- Bus-side controller for a bank of `register` instances sharing one data bus.
- Drives one-hot `oe`/`we` lines and the shared write bus.
- Reads the OR-combined register outputs. An unselected register drives 0, so the bank's outputs are OR-ed into `bus_in`.
- Sits between a simple valid/ready command source (sequencer/CPU core) and the register bank. Serves READ, WRITE and register-to-register MOVE, one transaction at a time.

---
 rtl/reg_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_reg_bus_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_ctrl.sv
// Bus-side controller for a bank of registers sharing one OR-combined data bus.
// Serves READ / WRITE / MOVE one at a time. Optional bus-idle checker: REG_BUS_CHECK_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module reg_bus_ctrl #(
    parameter int word_width = `WORD_WIDTH,
    parameter int num_regs   = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [addr_width-1:0] req_src,
    input  logic [addr_width-1:0] req_dst,
    input  logic [word_width-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [word_width-1:0] resp_data,
    output logic                  resp_err,
    output logic [num_regs-1:0]   reg_oe,
    output logic [num_regs-1:0]   reg_we,
    output logic [word_width-1:0] bus_out,
    input  logic [word_width-1:0] bus_in,
    output logic                  bus_fault
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        MV_RD,
        MV_WR,
        RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;

    localparam logic [addr_width:0] NUM_REGS_L = (addr_width + 1)'(num_regs);

    state_t                  state_reg;
    logic                    ready_reg;
    logic                    resp_valid_reg;
    logic                    resp_err_reg;
    logic [word_width-1:0]   resp_data_reg;
    logic [num_regs-1:0]     oe_reg;
    logic [num_regs-1:0]     we_reg;
    logic [word_width-1:0]   bus_out_reg;
    logic [word_width-1:0]   wdata_reg;
    logic [word_width-1:0]   hold_reg;
    logic                    err_pend_reg;

    logic [num_regs-1:0]     src_dec_req;
    logic [num_regs-1:0]     dst_dec_req;
    logic [num_regs-1:0]     dst_dec_reg;
    logic [addr_width-1:0]   dst_reg;
    logic                    src_bad;
    logic                    dst_bad;
    logic                    cmd_bad;

    // One-hot decoders: request-side feed the accept edge, held dst feeds MV_WR.
    genvar gi;
    generate
        for (gi = 0; gi < num_regs; gi++) begin : g_dec
            assign src_dec_req[gi] = (req_src == addr_width'(gi));
            assign dst_dec_req[gi] = (req_dst == addr_width'(gi));
            assign dst_dec_reg[gi] = (dst_reg == addr_width'(gi));
        end
    endgenerate

    assign src_bad = ({1'b0, req_src} >= NUM_REGS_L);
    assign dst_bad = ({1'b0, req_dst} >= NUM_REGS_L);

    always_comb begin
        cmd_bad = 1'b0;
        case (req_op)
            OP_READ:  cmd_bad = src_bad;
            OP_WRITE: cmd_bad = dst_bad;
            OP_MOVE:  cmd_bad = src_bad | dst_bad;
            default:  cmd_bad = 1'b1;
        endcase
    end

    // Strobes are cleared by default each cycle, so every pulse lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
            oe_reg         <= '0;
            we_reg         <= '0;
            bus_out_reg    <= '0;
            wdata_reg      <= '0;
            hold_reg       <= '0;
            dst_reg        <= '0;
            err_pend_reg   <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            oe_reg         <= '0;
            we_reg         <= '0;
            bus_out_reg    <= '0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && ready_reg) begin
                        ready_reg    <= 1'b0;
                        dst_reg      <= req_dst;
                        wdata_reg    <= req_wdata;
                        err_pend_reg <= cmd_bad;
                        if (cmd_bad) begin
                            state_reg <= RESP;
                        end else begin
                            case (req_op)
                                OP_READ: begin
                                    state_reg <= RD;
                                    oe_reg    <= src_dec_req;
                                end
                                OP_WRITE: begin
                                    state_reg   <= WR;
                                    we_reg      <= dst_dec_req;
                                    bus_out_reg <= req_wdata;
                                end
                                default: begin
                                    state_reg <= MV_RD;
                                    oe_reg    <= src_dec_req;
                                end
                            endcase
                        end
                    end
                end
                RD: begin
                    resp_data_reg <= bus_in;
                    state_reg     <= RESP;
                end
                WR: begin
                    resp_data_reg <= wdata_reg;
                    state_reg     <= RESP;
                end
                MV_RD: begin
                    // bus_in is what hold_reg captures this edge, so it can drive the write directly.
                    hold_reg    <= bus_in;
                    we_reg      <= dst_dec_reg;
                    bus_out_reg <= bus_in;
                    state_reg   <= MV_WR;
                end
                MV_WR: begin
                    resp_data_reg <= hold_reg;
                    state_reg     <= RESP;
                end
                RESP: begin
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= err_pend_reg;
                    ready_reg      <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_data  = resp_data_reg;
    assign reg_oe     = oe_reg;
    assign reg_we     = we_reg;
    assign bus_out    = bus_out_reg;

`ifdef REG_BUS_CHECK_EN
    // Any nonzero bus value while no register is enabled means contention; sticky until reset.
    logic bus_fault_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_fault_reg <= 1'b0;
        end else if ((oe_reg == '0) && (bus_in != '0)) begin
            bus_fault_reg <= 1'b1;
        end
    end

    assign bus_fault = bus_fault_reg;
`else
    assign bus_fault = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Self-checking bench for reg_bus_ctrl with a behavioural register bank on the bus.
`timescale 1ns/1ps

module tb_reg_bus_ctrl;

    localparam int W = 8;
    localparam int N = 8;
    localparam int A = 4;

`ifdef REG_BUS_CHECK_EN
    localparam logic FAULT_EXP = 1'b1;
`else
    localparam logic FAULT_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = '0;
    logic [A-1:0] req_src = '0;
    logic [A-1:0] req_dst = '0;
    logic [W-1:0] req_wdata = '0;
    logic         resp_valid;
    logic [W-1:0] resp_data;
    logic         resp_err;
    logic [N-1:0] reg_oe;
    logic [N-1:0] reg_we;
    logic [W-1:0] bus_out;
    logic [W-1:0] bus_in;
    logic         bus_fault;

    reg_bus_ctrl #(.word_width(W), .num_regs(N), .addr_width(A)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src(req_src), .req_dst(req_dst), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .reg_oe(reg_oe), .reg_we(reg_we), .bus_out(bus_out), .bus_in(bus_in),
        .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    // Register bank: unselected registers drive 0, outputs OR-ed onto bus_in.
    logic [W-1:0] bank [N];
    logic [W-1:0] bus_force = '0;

    always_comb begin
        bus_in = bus_force;
        for (int i = 0; i < N; i++)
            if (reg_oe[i]) bus_in = bus_in | bank[i];
    end

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (reg_we[i]) bank[i] <= bus_out;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] exp_mem [N];

    // Response monitor and bus invariants.
    always @(negedge clk) begin
        exp_t e;
        tests_run++;
        if ($countones(reg_oe) > 1 || $countones(reg_we) > 1 ||
            (reg_oe != '0 && reg_we != '0) || (reg_we == '0 && bus_out != '0)) begin
            tests_failed++;
            $display("FAIL bus_invariant cyc=%0d oe=%h we=%h bus_out=%h", cyc, reg_oe, reg_we, bus_out);
        end
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_resp cyc=%0d data=%h err=%b", cyc, resp_data, resp_err);
            end else begin
                e = sbq.pop_front();
                if (resp_err !== e.err || cyc != e.due || (!e.err && resp_data !== e.data)) begin
                    tests_failed++;
                    $display("FAIL resp cyc=%0d got data=%h err=%b, expected data=%h err=%b at cyc=%0d",
                             cyc, resp_data, resp_err, e.data, e.err, e.due);
                end else begin
                    $display("[TB] resp ok cyc=%0d data=%h err=%b", cyc, resp_data, resp_err);
                end
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            e = sbq.pop_front();
            tests_failed++;
            $display("FAIL resp_timeout cyc=%0d no resp_valid, expected at cyc=%0d", cyc, e.due);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [A-1:0] src, input logic [A-1:0] dst,
                         input logic [W-1:0] wd, input bit expect_resp, output int acc);
        exp_t e;
        bit   bad;
        int   k;
        bad = (op == 2'b11) || (op == 2'b00 && src >= N) || (op == 2'b01 && dst >= N) ||
              (op == 2'b10 && (src >= N || dst >= N));
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout req_ready=%b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_wdata = wd;
        acc = cyc + 1;
        if (expect_resp) begin
            e.err  = bad;
            e.data = '0;
            if (bad) begin
                e.due = acc + 1;
            end else if (op == 2'b00) begin
                e.data = exp_mem[src[2:0]];
                e.due  = acc + 2;
            end else if (op == 2'b01) begin
                e.data = wd;
                e.due  = acc + 2;
                exp_mem[dst[2:0]] = wd;
            end else begin
                e.data = exp_mem[src[2:0]];
                e.due  = acc + 3;
                exp_mem[dst[2:0]] = exp_mem[src[2:0]];
            end
            sbq.push_back(e);
        end
        $display("[TB] issue op=%0d src=%0d dst=%0d wdata=%h acc=%0d", op, src, dst, wd, acc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_src   = A'($urandom);
        req_dst   = A'($urandom);
        req_wdata = W'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (sbq.size() != 0) begin
            tests_failed++;
            $display("FAIL drain pending=%0d expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, bus_fault} !== 4'b1000 ||
            resp_data !== '0 || reg_oe !== '0 || reg_we !== '0 || bus_out !== '0) begin
            tests_failed++;
            $display("FAIL reset ready=%b rv=%b re=%b bf=%b rd=%h oe=%h we=%h bo=%h expected ready=1 rest 0",
                     req_ready, resp_valid, resp_err, bus_fault, resp_data, reg_oe, reg_we, bus_out);
        end
    endtask

    task automatic test_write();
        int acc;
        issue(2'b01, 4'd0, 4'd3, 8'hA5, 1, acc);
        @(negedge clk);
        tests_run++;
        if (reg_we !== 8'h08 || bus_out !== 8'hA5 || reg_oe !== '0) begin
            tests_failed++;
            $display("FAIL write_pulse we=%h bus_out=%h oe=%h expected 08 a5 00", reg_we, bus_out, reg_oe);
        end
        @(negedge clk);
        tests_run++;
        if (reg_we !== '0 || bus_out !== '0) begin
            tests_failed++;
            $display("FAIL write_end we=%h bus_out=%h expected 00 00", reg_we, bus_out);
        end
        drain();
    endtask

    task automatic test_read();
        int acc;
        issue(2'b00, 4'd3, 4'd0, 8'h00, 1, acc);
        @(negedge clk);
        tests_run++;
        if (reg_oe !== 8'h08 || reg_we !== '0) begin
            tests_failed++;
            $display("FAIL read_pulse oe=%h we=%h expected 08 00", reg_oe, reg_we);
        end
        @(negedge clk);
        tests_run++;
        if (reg_oe !== '0) begin
            tests_failed++;
            $display("FAIL read_end oe=%h expected 00", reg_oe);
        end
        drain();
    endtask

    task automatic test_move();
        int acc;
        issue(2'b10, 4'd3, 4'd5, 8'h00, 1, acc);
        @(negedge clk);
        tests_run++;
        if (reg_oe !== 8'h08 || reg_we !== '0) begin
            tests_failed++;
            $display("FAIL move_rd oe=%h we=%h expected 08 00", reg_oe, reg_we);
        end
        @(negedge clk);
        tests_run++;
        if (reg_we !== 8'h20 || bus_out !== 8'hA5 || reg_oe !== '0) begin
            tests_failed++;
            $display("FAIL move_wr we=%h bus_out=%h oe=%h expected 20 a5 00", reg_we, bus_out, reg_oe);
        end
        @(negedge clk);
        tests_run++;
        if (reg_we !== '0) begin
            tests_failed++;
            $display("FAIL move_end we=%h expected 00", reg_we);
        end
        drain();
        issue(2'b00, 4'd5, 4'd0, 8'h00, 1, acc);
        drain();
        issue(2'b10, 4'd5, 4'd5, 8'h00, 1, acc);
        drain();
    endtask

    task automatic test_errors();
        int acc;
        logic [1:0]   ops [3] = '{2'b00, 2'b11, 2'b10};
        logic [A-1:0] srcs [3] = '{4'd9, 4'd1, 4'd2};
        logic [A-1:0] dsts [3] = '{4'd0, 4'd2, 4'd12};
        for (int t = 0; t < 3; t++) begin
            issue(ops[t], srcs[t], dsts[t], 8'h11, 1, acc);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                tests_run++;
                if (reg_oe !== '0 || reg_we !== '0) begin
                    tests_failed++;
                    $display("FAIL err_bus_quiet case=%0d oe=%h we=%h expected 00 00", t, reg_oe, reg_we);
                end
            end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        issue(2'b01, 4'd0, 4'd6, 8'h3C, 1, acc);
        drain();
        issue(2'b01, 4'd0, 4'd7, 8'h77, 1, acc);
        drain();
        issue(2'b10, 4'd6, 4'd7, 8'h00, 0, acc);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (reg_oe !== '0 || reg_we !== '0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid oe=%h we=%h ready=%b expected 00 00 1", reg_oe, reg_we, req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (reg_we !== '0 || resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_quiet we=%h resp_valid=%b expected 00 0", reg_we, resp_valid);
            end
        end
        issue(2'b00, 4'd7, 4'd0, 8'h00, 1, acc);
        drain();
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3, a4;
        issue(2'b01, 4'd0, 4'd2, 8'h5A, 1, a1);
        issue(2'b00, 4'd2, 4'd0, 8'h00, 1, a2);
        issue(2'b10, 4'd2, 4'd4, 8'h00, 1, a3);
        issue(2'b00, 4'd4, 4'd0, 8'h00, 1, a4);
        tests_run++;
        if (a2 - a1 != 3 || a3 - a2 != 3 || a4 - a3 != 4) begin
            tests_failed++;
            $display("FAIL throughput gaps=%0d,%0d,%0d expected 3,3,4", a2 - a1, a3 - a2, a4 - a3);
        end
        for (int t = 0; t < 12; t++) begin
            logic [1:0]   op;
            logic [A-1:0] s;
            logic [A-1:0] d;
            op = 2'($urandom_range(0, 3));
            s  = A'($urandom_range(0, 8));
            d  = A'($urandom_range(0, 8));
            issue(op, s, d, W'($urandom), 1, a1);
        end
        drain();
    endtask

    task automatic test_bus_fault();
        @(negedge clk);
        tests_run++;
        if (bus_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clean bus_fault=%b expected 0", bus_fault);
        end
        bus_force = 8'h01;
        @(negedge clk);
        bus_force = 8'h00;
        tests_run++;
        if (bus_fault !== FAULT_EXP) begin
            tests_failed++;
            $display("FAIL fault_set bus_fault=%b expected %b", bus_fault, FAULT_EXP);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_fault !== FAULT_EXP) begin
            tests_failed++;
            $display("FAIL fault_sticky bus_fault=%b expected %b", bus_fault, FAULT_EXP);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clear bus_fault=%b expected 0", bus_fault);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            bank[i]    = '0;
            exp_mem[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_move();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_bus_fault();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
